// File: rtl/nibble_seq_adder_pkg.sv
// nibble_seq_adder_pkg
// Shared definitions for the nibble-serial adder: FSM state encodings and
// the width of one arithmetic slice. Imported by the interface, the CLA
// slice and the top level.
package nibble_seq_adder_pkg;

    // Width of one carry-lookahead slice; operands are processed this many
    // bits per clock.
    localparam int NIBBLE_W = 4;

    // Sequencer states. The encoding is fixed so external tools and waves
    // see stable values.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_seq_adder_if.sv
// nibble_seq_adder_if
// Groups the operand handshake and the result handshake of the
// nibble-serial adder.
//   in_valid/in_ready   : operand handshake (producer -> adder)
//   a, b, sub           : operands and operation select (0 = add, 1 = sub)
//   out_valid/out_ready : result handshake (adder -> consumer)
//   sum, cout, ovf, zero: result and flags
// Modports: master = the environment driving operands and consuming
// results, slave = the adder itself.
interface nibble_seq_adder_if
    import nibble_seq_adder_pkg::*;
#(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface

// File: rtl/nibble_seq_adder_cla4.sv
// cla4_slice
// Purely combinational 4-bit carry-lookahead adder slice.
//   a, b : nibble operands
//   cin  : carry into bit 0
//   s    : nibble sum
//   c3   : carry into bit 3 (needed for signed-overflow detection)
//   cout : carry out of bit 3
module cla4_slice
    import nibble_seq_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                c3,
    output logic                cout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    // Generate/propagate terms, then every carry is expanded directly from
    // them and cin so no carry ripples through another.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c[NIBBLE_W-1:0];
        c3   = c[3];
        cout = c[4];
    end

endmodule

// File: rtl/nibble_seq_adder.sv
// nibble_seq_adder
// Sequential WIDTH-bit adder/subtractor that processes one nibble per clock
// through a single 4-bit carry-lookahead slice. A result appears WIDTH/4
// clocks after the operands are accepted and is held until consumed.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_seq_adder_if (operand and result handshakes)
module nibble_seq_adder
    import nibble_seq_adder_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic                clk,
    input  logic                rst_n,
    nibble_seq_adder_if.slave   bus
);

    localparam int NUM_NIB = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NIB - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [NIBBLE_W-1:0] sliceA;
    logic [NIBBLE_W-1:0] sliceB;
    logic [NIBBLE_W-1:0] sliceS;
    logic                sliceC3;
    logic                sliceCout;

    // Select the nibble currently being worked on.
    assign sliceA = opA_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign sliceB = opB_q[idx_q*NIBBLE_W +: NIBBLE_W];

    cla4_slice u_slice (
        .a    (sliceA),
        .b    (sliceB),
        .cin  (carry_q),
        .s    (sliceS),
        .c3   (sliceC3),
        .cout (sliceCout)
    );

    // Next-state and datapath update. Subtraction is done as A + ~B + 1:
    // B is inverted when latched and the carry register is seeded with sub.
    // The flags are only written on the final nibble so they describe the
    // whole word, and ovf compares carries around the MSB.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    opA_d   = bus.a;
                    opB_d   = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = sliceS;
                carry_d = sliceCout;
                if (idx_q == IDX_LAST) begin
                    cout_d  = sliceCout;
                    ovf_d   = sliceC3 ^ sliceCout;
                    zero_d  = (sum_d == '0);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // Handshakes come straight from the state; results from registers.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.sum       = sum_q;
        bus.cout      = cout_q;
        bus.ovf       = ovf_q;
        bus.zero      = zero_q;
    end

endmodule

// File: tb/tb_nibble_seq_adder.sv
// tb_nibble_seq_adder
// Directed-vector bench for nibble_seq_adder. The stimulus process issues
// operand sets and pushes the hand-computed result into a scoreboard queue;
// a monitor pops and compares whenever the adder raises out_valid.
module tb_nibble_seq_adder;

    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        int               acceptCycle;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cycleCnt;
    int   compared;
    int   mismatched;
    exp_t sbQ[$];
    logic prevValid;

    nibble_seq_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to measure accept-to-result latency.
    initial cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Safety net in case a handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation timed out");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Issue one operand set starting from a falling edge. When expectResult
    // is set, the hand-computed answer goes into the scoreboard.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub, input logic [WIDTH-1:0] expSum,
                                 input logic expCout, input logic expOvf,
                                 input logic expZero, input bit expectResult);
        exp_t e;
        int   waited;
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            checkOutput("accept_timeout", 32'(bus.in_ready), 32'd1);
        end
        bus.a        = a;
        bus.b        = b;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        if (expectResult) begin
            e.sum         = expSum;
            e.cout        = expCout;
            e.ovf         = expOvf;
            e.zero        = expZero;
            e.acceptCycle = cycleCnt + 1;
            sbQ.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = WIDTH'($urandom);
        bus.b        = WIDTH'($urandom);
        bus.sub      = 1'($urandom);
    endtask

    // Wait on falling edges until the adder is idle again.
    task automatic waitIdle();
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            checkOutput("idle_timeout", 32'(bus.in_ready), 32'd1);
        end
    endtask

    // Monitor: every new result is matched against the oldest expectation.
    initial prevValid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && !prevValid) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("sum", 32'(bus.sum), 32'(e.sum));
                checkOutput("cout", 32'(bus.cout), 32'(e.cout));
                checkOutput("ovf", 32'(bus.ovf), 32'(e.ovf));
                checkOutput("zero", 32'(bus.zero), 32'(e.zero));
                checkOutput("latency", 32'(cycleCnt - e.acceptCycle), 32'd4);
            end
        end
        prevValid = bus.out_valid;
    end

    initial begin
        int waited;
        compared      = 0;
        mismatched    = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Outputs while held in reset.
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_sum", 32'(bus.sum), 32'd0);
        checkOutput("rst_flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);

        // Release and accept on the very next rising edge.
        rst_n = 1'b1;
        applyStimulus(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(16'h0007, 16'h0007, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        waitIdle();

        // Last result persists in IDLE.
        checkOutput("idle_hold_sum", 32'(bus.sum), 32'hFFFF);

        // Backpressure: consumer stalls for three cycles in DONE.
        bus.out_ready = 1'b0;
        applyStimulus(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b0, 1'b1);
        waited = 0;
        while (!bus.out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("stall_sum", 32'(bus.sum), 32'hBCDE);
            checkOutput("stall_flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("release_out_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
        waitIdle();

        // Reset two edges into an operation: no result may appear.
        applyStimulus(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_sum", 32'(bus.sum), 32'd0);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
        waitIdle();

        // Every expectation must have been matched.
        waited = 0;
        while (sbQ.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
